// File: rtl/apb_arbiter_2m.sv
// Two-master to one-slave APB arbiter.
// Round-robin arbitration between m0 and m1; the granted transfer is re-issued
// to the slave as a clean SETUP/ACCESS sequence and the response is routed back
// to the granted master only. A per-transfer timeout ends transfers to a hung slave.
//
// Ports:
//   clock, reset          : clock (rising edge), asynchronous active-high reset
//   mN_paddr/psel/penable/pprot/pwrite/pwdata/pstrb : master N request (penable ignored)
//   mN_pready/prdata/pslverr : master N response (combinational from slave response)
//   out_paddr/psel/penable/pprot/pwrite/pwdata/pstrb : registered slave-side request
//   out_pready/prdata/pslverr : slave response
module apb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m0_paddr,
  input  logic        m0_psel,
  input  logic        m0_penable,
  input  logic [2:0]  m0_pprot,
  input  logic        m0_pwrite,
  input  logic [31:0] m0_pwdata,
  input  logic [3:0]  m0_pstrb,
  output logic        m0_pready,
  output logic [31:0] m0_prdata,
  output logic        m0_pslverr,
  input  logic [31:0] m1_paddr,
  input  logic        m1_psel,
  input  logic        m1_penable,
  input  logic [2:0]  m1_pprot,
  input  logic        m1_pwrite,
  input  logic [31:0] m1_pwdata,
  input  logic [3:0]  m1_pstrb,
  output logic        m1_pready,
  output logic [31:0] m1_prdata,
  output logic        m1_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state, state_nxt;
  logic            grant;
  logic            last;
  logic [TO_W-1:0] cnt;
  logic            req_grant_c;
  logic            timeout_hit_c;
  logic            done_c;
  logic [31:0]     rsp_data_c;
  logic            rsp_err_c;

  // Master-side penable carries no information for a re-sequencing arbiter.
  logic unused_penable_c;
  assign unused_penable_c = m0_penable ^ m1_penable;

  // Round-robin pick: a lone requester wins; on a tie the master that went last loses.
  always_comb begin
    req_grant_c = m1_psel;
    if (m0_psel && m1_psel) begin
      req_grant_c = ~last;
    end
  end

  assign timeout_hit_c = (TIMEOUT != 0) && (cnt == TO_LAST);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; done_c marks the last ACCESS cycle (ready or timeout).
  always_comb begin
    state_nxt = state;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (m0_psel || m1_psel) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (out_pready || timeout_hit_c) begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Response payload: slave data on reads only; a timeout reports an error with zero data.
  always_comb begin
    rsp_data_c = 32'h0;
    rsp_err_c  = 1'b1;
    if (out_pready) begin
      rsp_data_c = out_pwrite ? 32'h0 : out_prdata;
      rsp_err_c  = out_pslverr;
    end
  end

  // Combinational response path, so the master completes in the same cycle as the slave.
  always_comb begin
    m0_pready  = 1'b0;
    m0_prdata  = 32'h0;
    m0_pslverr = 1'b0;
    m1_pready  = 1'b0;
    m1_prdata  = 32'h0;
    m1_pslverr = 1'b0;
    if (done_c) begin
      if (grant) begin
        m1_pready  = 1'b1;
        m1_prdata  = rsp_data_c;
        m1_pslverr = rsp_err_c;
      end else begin
        m0_pready  = 1'b1;
        m0_prdata  = rsp_data_c;
        m0_pslverr = rsp_err_c;
      end
    end
  end

  // Grant, request latch, slave handshake and timeout counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant       <= 1'b0;
      last        <= 1'b1;
      cnt         <= '0;
      out_paddr   <= 32'h0;
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      out_pprot   <= 3'h0;
      out_pwrite  <= 1'b0;
      out_pwdata  <= 32'h0;
      out_pstrb   <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_psel || m1_psel) begin
            grant    <= req_grant_c;
            out_psel <= 1'b1;
            if (req_grant_c) begin
              out_paddr  <= m1_paddr;
              out_pprot  <= m1_pprot;
              out_pwrite <= m1_pwrite;
              out_pwdata <= m1_pwdata;
              out_pstrb  <= m1_pstrb;
            end else begin
              out_paddr  <= m0_paddr;
              out_pprot  <= m0_pprot;
              out_pwrite <= m0_pwrite;
              out_pwdata <= m0_pwdata;
              out_pstrb  <= m0_pstrb;
            end
          end
        end
        SETUP: begin
          out_penable <= 1'b1;
          cnt         <= '0;
        end
        ACCESS: begin
          if (done_c) begin
            // A timed-out master also counts as served, so it cannot starve the other.
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            last        <= grant;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter_2m.sv
module tb_apb_arbiter_2m;

  logic        clock;
  logic        reset;
  logic [31:0] m0_paddr, m1_paddr, m0_pwdata, m1_pwdata;
  logic        m0_psel, m1_psel, m0_penable, m1_penable, m0_pwrite, m1_pwrite;
  logic [2:0]  m0_pprot, m1_pprot;
  logic [3:0]  m0_pstrb, m1_pstrb;
  logic        m0_pready, m1_pready, m0_pslverr, m1_pslverr;
  logic [31:0] m0_prdata, m1_prdata;
  logic [31:0] out_paddr, out_pwdata, out_prdata;
  logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;

  int n_cmp;
  int n_fail;

  apb_arbiter_2m #(.TIMEOUT(4), .TO_W(8)) dut (
    .clock(clock), .reset(reset),
    .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pprot(m0_pprot),
    .m0_pwrite(m0_pwrite), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
    .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
    .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pprot(m1_pprot),
    .m1_pwrite(m1_pwrite), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
    .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot),
    .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
    .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        p0, p1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic [31:0] srd;    // slave prdata
    logic        serr;   // slave pslverr
    logic        g;      // expected grant
    logic [31:0] ea, ed; // expected out_paddr / out_pwdata
    logic        ew;     // expected out_pwrite
    logic [31:0] erd;    // expected master prdata
    logic        eerr;   // expected master pslverr
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one zero-wait transfer starting in an IDLE cycle; ends in the next IDLE cycle.
  task automatic do_vec(input vec_t v);
    m0_psel = v.p0; m0_pwrite = v.w0; m0_paddr = v.a0; m0_pwdata = v.d0;
    m1_psel = v.p1; m1_pwrite = v.w1; m1_paddr = v.a1; m1_pwdata = v.d1;
    out_pready = 1'b1; out_prdata = v.srd; out_pslverr = v.serr;
    #1;
    chk("idle_psel", 32'(out_psel), 32'd0);
    step();
    chk("setup_psel", 32'(out_psel), 32'd1);
    chk("setup_penable", 32'(out_penable), 32'd0);
    chk("setup_paddr", out_paddr, v.ea);
    chk("setup_pwdata", out_pwdata, v.ed);
    chk("setup_pwrite", 32'(out_pwrite), 32'(v.ew));
    chk("setup_pprot", 32'(out_pprot), v.g ? 32'h2 : 32'h1);
    chk("setup_pstrb", 32'(out_pstrb), v.g ? 32'h3 : 32'hF);
    chk("setup_m0_pready", 32'(m0_pready), 32'd0);
    chk("setup_m1_pready", 32'(m1_pready), 32'd0);
    step();
    chk("access_penable", 32'(out_penable), 32'd1);
    if (v.g) begin
      chk("m1_pready", 32'(m1_pready), 32'd1);
      chk("m1_prdata", m1_prdata, v.erd);
      chk("m1_pslverr", 32'(m1_pslverr), 32'(v.eerr));
      chk("m0_idle_pready", 32'(m0_pready), 32'd0);
      chk("m0_idle_prdata", m0_prdata, 32'd0);
    end else begin
      chk("m0_pready", 32'(m0_pready), 32'd1);
      chk("m0_prdata", m0_prdata, v.erd);
      chk("m0_pslverr", 32'(m0_pslverr), 32'(v.eerr));
      chk("m1_idle_pready", 32'(m1_pready), 32'd0);
      chk("m1_idle_prdata", m1_prdata, 32'd0);
    end
    m0_psel = 1'b0; m1_psel = 1'b0;
    step();
    chk("post_psel", 32'(out_psel), 32'd0);
    chk("post_penable", 32'(out_penable), 32'd0);
  endtask

  initial begin
    vec_t v;
    int n0, n1;
    logic exp_g;
    n_cmp = 0; n_fail = 0;
    reset = 1'b1;
    m0_paddr = '0; m0_psel = 0; m0_penable = 0; m0_pprot = 3'h1; m0_pwrite = 0; m0_pwdata = '0; m0_pstrb = 4'hF;
    m1_paddr = '0; m1_psel = 0; m1_penable = 0; m1_pprot = 3'h2; m1_pwrite = 0; m1_pwdata = '0; m1_pstrb = 4'h3;
    out_pready = 0; out_prdata = '0; out_pslverr = 0;

    // p0 p1 w0 w1 a0 a1 d0 d1 srd serr g ea ed ew erd eerr
    vecs[0] = '{1,0,0,0, 32'h1000_0004, 32'h0, 32'h0, 32'h0, 32'h0000_A5A5, 0, 0, 32'h1000_0004, 32'h0, 0, 32'h0000_A5A5, 0};
    vecs[1] = '{0,1,0,0, 32'h0, 32'h2000_0010, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 1, 32'h2000_0010, 32'h0, 0, 32'hDEAD_BEEF, 0};
    vecs[2] = '{1,1,1,1, 32'h0, 32'h8, 32'h1234, 32'h5678, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h1234, 1, 32'h0, 0};
    vecs[3] = '{1,1,1,1, 32'h0, 32'h8, 32'h1234, 32'h5678, 32'hFFFF_FFFF, 0, 1, 32'h8, 32'h5678, 1, 32'h0, 0};
    vecs[4] = '{0,1,0,1, 32'h0, 32'h24, 32'h0, 32'h9999, 32'h0, 0, 1, 32'h24, 32'h9999, 1, 32'h0, 0};
    vecs[5] = '{1,0,0,0, 32'h44, 32'h0, 32'h0, 32'h0, 32'h77, 1, 0, 32'h44, 32'h0, 0, 32'h77, 1};

    // Reset state
    #12;
    chk("rst_psel", 32'(out_psel), 32'd0);
    chk("rst_penable", 32'(out_penable), 32'd0);
    chk("rst_paddr", out_paddr, 32'd0);
    chk("rst_pwdata", out_pwdata, 32'd0);
    chk("rst_m0_pready", 32'(m0_pready), 32'd0);
    chk("rst_m1_pready", 32'(m1_pready), 32'd0);
    step();
    reset = 1'b0;

    foreach (vecs[i]) do_vec(vecs[i]);

    // Wait states: three low-ready ACCESS cycles; request must stay frozen.
    m0_psel = 1; m0_pwrite = 1; m0_paddr = 32'h3000_0000; m0_pwdata = 32'hCAFE_0001;
    out_pready = 0;
    step();
    chk("ws_setup_psel", 32'(out_psel), 32'd1);
    m0_paddr = 32'h0000_0BAD; m0_pwdata = 32'h0000_0BAD;
    for (int k = 1; k <= 4; k++) begin
      step();
      out_pready = (k == 4);
      #1;
      chk("ws_penable", 32'(out_penable), 32'd1);
      chk("ws_paddr", out_paddr, 32'h3000_0000);
      chk("ws_pwdata", out_pwdata, 32'hCAFE_0001);
      chk("ws_m0_pready", 32'(m0_pready), (k == 4) ? 32'd1 : 32'd0);
    end
    m0_psel = 0;
    step();
    chk("ws_end_penable", 32'(out_penable), 32'd0);

    // Timeout: slave never ready, m1 read ends with error after 4 ACCESS cycles.
    m1_psel = 1; m1_pwrite = 0; m1_paddr = 32'h4000_0000;
    out_pready = 0; out_prdata = 32'h0000_1111; out_pslverr = 0;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("to_penable", 32'(out_penable), 32'd1);
      chk("to_m1_pready", 32'(m1_pready), (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) begin
        chk("to_m1_pslverr", 32'(m1_pslverr), 32'd1);
        chk("to_m1_prdata", m1_prdata, 32'd0);
        chk("to_m0_pready", 32'(m0_pready), 32'd0);
      end
    end
    m1_psel = 0;
    step();
    chk("to_idle_psel", 32'(out_psel), 32'd0);
    v = '{1,0,0,0, 32'h50, 32'h0, 32'h0, 32'h0, 32'h0000_2222, 0, 0, 32'h50, 32'h0, 0, 32'h0000_2222, 0};
    do_vec(v);

    // Reset asserted while in ACCESS.
    m1_psel = 1; m1_paddr = 32'h60; out_pready = 0;
    step();
    step();
    chk("pre_rst_penable", 32'(out_penable), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_psel", 32'(out_psel), 32'd0);
    chk("arst_penable", 32'(out_penable), 32'd0);
    chk("arst_m0_pready", 32'(m0_pready), 32'd0);
    chk("arst_m1_pready", 32'(m1_pready), 32'd0);
    m1_psel = 0;
    step();
    reset = 1'b0;

    // Round robin under continuous load from both masters; first tie after reset goes to m0.
    n0 = 0; n1 = 0;
    m0_pwrite = 0; m1_pwrite = 0; out_pready = 1; out_prdata = 32'h0;
    m0_paddr = 32'h100; m1_paddr = 32'h200; m0_psel = 1; m1_psel = 1;
    for (int i = 0; i < 8; i++) begin
      exp_g = 1'(i % 2);
      step();
      chk("rr_paddr", out_paddr, exp_g ? 32'h200 + 32'(4 * n1) : 32'h100 + 32'(4 * n0));
      step();
      chk("rr_m0_pready", 32'(m0_pready), exp_g ? 32'd0 : 32'd1);
      chk("rr_m1_pready", 32'(m1_pready), exp_g ? 32'd1 : 32'd0);
      if (exp_g) begin
        n1++; m1_paddr = 32'h200 + 32'(4 * n1);
      end else begin
        n0++; m0_paddr = 32'h100 + 32'(4 * n0);
      end
      step();
    end
    m0_psel = 0; m1_psel = 0;
    step();
    chk("rr_end_psel", 32'(out_psel), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
